// File: rtl/rs_2d_pkg.sv
// Shared RS(30,24) constants and types for the 2-D RS BER path.
// Also holds the beat-count helper used for width checks.
package rs_2d_pkg;

  localparam int RS_N  = 30;
  localparam int RS_K  = 24;
  localparam int SYM_W = 8;

  typedef logic [RS_N*SYM_W-1:0] rs_cw_t;

  // Returns 0 when out_w does not tile the codeword exactly.
  function automatic int beats(
    input int out_w,
    input int bits = RS_N*SYM_W
  );
    if (out_w <= 0)
      return 0;
    if (bits % out_w != 0)
      return 0;
    return bits / out_w;
  endfunction

endpackage

// File: rtl/rs_cw_serializer_if.sv
// Codeword-in / beat-out handshake bundle for the serializer.
// master = encoder/channel side, slave = serializer.
interface rs_cw_serializer_if #(
  parameter int N_BYTES = 30,
  parameter int OUT_W   = 8
);

  logic [8*N_BYTES-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_first;
  logic                 out_last;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output out_first,
    output out_last
  );

endinterface

// File: rtl/rs_cw_serializer.sv
// Two-slot ping-pong buffer that turns parallel RS codewords
// into OUT_W-bit valid/ready beats, byte 0 first.
module rs_cw_serializer
  import rs_2d_pkg::*;
#(
  parameter int N_BYTES    = 30,
  parameter int OUT_W      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rs_cw_serializer_if.slave     bus,
  output logic                  ovf_err,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [31:0]           cw_cnt
);

  localparam int CW_W  = 8*N_BYTES;
  localparam int BEATS = beats(OUT_W, CW_W);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (BEATS == 0) begin : g_bad_out_w
    $error("rs_cw_serializer: OUT_W must divide 8*N_BYTES");
  end

  localparam logic [BW-1:0] LAST = BW'(BEATS-1);

  typedef logic [BEATS-1:0][OUT_W-1:0] cw_beats_t;

  cw_beats_t      slot [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     occ;
  logic [BW-1:0]  beat;

  logic accept;
  logic drop;
  logic xfer;
  logic at_last;
  logic pop;

  // in_ready depends on occupancy only, so no path from out_ready.
  assign bus.in_ready  = (occ != 2'd2);
  assign bus.out_valid = (occ != 2'd0);

  assign accept  = bus.in_valid & bus.in_ready;
  assign drop    = bus.in_valid & ~bus.in_ready;
  assign at_last = (beat == LAST);
  assign xfer    = bus.out_valid & bus.out_ready;
  assign pop     = xfer & at_last;

  assign bus.out_data  = bus.out_valid
                       ? slot[rd_ptr][beat]
                       : '0;
  assign bus.out_first = bus.out_valid & (beat == '0);
  assign bus.out_last  = bus.out_valid & at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0]  <= '0;
      slot[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      beat     <= '0;
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
      cw_cnt   <= '0;
    end else begin
      // wr_ptr always names the free slot whenever in_ready is high.
      if (accept) begin
        slot[wr_ptr] <= bus.in_data;
        wr_ptr       <= ~wr_ptr;
      end

      if (drop) begin
        ovf_err <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + 1'b1;
      end

      if (xfer) begin
        if (at_last) begin
          beat   <= '0;
          rd_ptr <= ~rd_ptr;
          cw_cnt <= cw_cnt + 32'd1;
        end else begin
          beat <= beat + 1'b1;
        end
      end

      unique case (1'b1)
        accept & ~pop: occ <= occ + 2'd1;
        pop & ~accept: occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_cw_serializer.sv
// Directed + random bench for rs_cw_serializer, checked against
// a queue-of-codewords reference model.
module tb_rs_cw_serializer;
  import rs_2d_pkg::*;

  localparam int NB = 30;
  localparam int BEATS8 = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_cw_serializer_if #(.N_BYTES(NB), .OUT_W(8))  bus8  ();
  rs_cw_serializer_if #(.N_BYTES(NB), .OUT_W(40)) bus40 ();

  logic        ovf8,  ovf40;
  logic [15:0] drop8, drop40;
  logic [31:0] cw8,   cw40;

  rs_cw_serializer #(.N_BYTES(NB), .OUT_W(8), .DROP_CNT_W(16)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus8.slave),
    .ovf_err  (ovf8),
    .drop_cnt (drop8),
    .cw_cnt   (cw8)
  );

  rs_cw_serializer #(.N_BYTES(NB), .OUT_W(40), .DROP_CNT_W(16)) dut40 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus40.slave),
    .ovf_err  (ovf40),
    .drop_cnt (drop40),
    .cw_cnt   (cw40)
  );

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "init";

  // Reference model: codewords waiting/being sent, byte index in head.
  rs_cw_t q[$];
  int     m_beat = 0;
  int     m_cw   = 0;
  int     m_drop = 0;
  bit     m_ovf  = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %0h expected %0h",
             phase, tag, obs, exp);
    end
  endtask

  function automatic rs_cw_t rnd_cw();
    rs_cw_t c;
    for (int k = 0; k < NB; k++)
      c[8*k +: 8] = 8'($urandom);
    return c;
  endfunction

  task automatic tick(input bit iv, input rs_cw_t d,
                      input bit ordy, input bit r = 1'b0);
    bit     e_rdy;
    bit     e_val;
    rs_cw_t head;
    @(negedge clk);
    rst            = r;
    bus8.in_valid  = iv;
    bus8.in_data   = d;
    bus8.out_ready = ordy;
    #1;
    e_rdy = (q.size() < 2);
    e_val = (q.size() != 0);
    head  = e_val ? q[0] : '0;
    check("out_valid", bus8.out_valid, e_val);
    check("out_data",  bus8.out_data,  head[8*m_beat +: 8]);
    check("out_first", bus8.out_first, e_val && m_beat == 0);
    check("out_last",  bus8.out_last,  e_val && m_beat == BEATS8-1);
    check("in_ready",  bus8.in_ready,  e_rdy);
    check("ovf_err",   ovf8,  m_ovf);
    check("drop_cnt",  drop8, m_drop);
    check("cw_cnt",    cw8,   32'(m_cw));
    if (r) begin
      q.delete();
      m_beat = 0;
      m_cw   = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (e_val && ordy) begin
        m_beat++;
        if (m_beat == BEATS8) begin
          m_beat = 0;
          void'(q.pop_front());
          m_cw++;
        end
      end
      if (iv) begin
        if (e_rdy) begin
          q.push_back(d);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 65535)
            m_drop++;
        end
      end
    end
  endtask

  initial begin
    rs_cw_t d_inc;
    rs_cw_t d_idx;
    rs_cw_t cw_a;
    rs_cw_t cw_b;
    logic [39:0] e40;

    for (int k = 0; k < NB; k++) begin
      d_inc[8*k +: 8] = 8'(k + 1);
      d_idx[8*k +: 8] = 8'(k);
      cw_a[8*k +: 8]  = 8'hAA;
      cw_b[8*k +: 8]  = 8'h55;
    end

    bus8.in_valid   = 1'b0;
    bus8.in_data    = '0;
    bus8.out_ready  = 1'b0;
    bus40.in_valid  = 1'b0;
    bus40.in_data   = '0;
    bus40.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    phase = "reset";
    repeat (2) tick(1'b0, '0, 1'b1);

    phase = "single";
    tick(1'b1, d_inc, 1'b1);
    repeat (32) tick(1'b0, '0, 1'b1);

    phase = "b2b";
    tick(1'b1, cw_a, 1'b1);
    tick(1'b1, cw_b, 1'b1);
    repeat (62) tick(1'b0, '0, 1'b1);

    phase = "stall";
    tick(1'b1, d_inc, 1'($urandom_range(0, 1)));
    repeat (80) tick(1'b0, '0, 1'($urandom_range(0, 1)));
    repeat (35) tick(1'b0, '0, 1'b1);

    phase = "overflow";
    repeat (3) tick(1'b1, rnd_cw(), 1'b0);
    repeat (5) tick(1'b0, '0, 1'b0);
    repeat (65) tick(1'b0, '0, 1'b1);

    phase = "random";
    repeat (400)
      tick($urandom_range(0, 3) == 0, rnd_cw(),
           $urandom_range(0, 3) != 0);
    repeat (70) tick(1'b0, '0, 1'b1);

    phase = "reset_mid";
    tick(1'b1, d_inc, 1'b1);
    repeat (10) tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b1);
    repeat (2) tick(1'b0, '0, 1'b1);
    tick(1'b1, d_inc, 1'b1);
    repeat (32) tick(1'b0, '0, 1'b1);

    phase = "w40";
    @(negedge clk);
    bus40.in_valid = 1'b1;
    bus40.in_data  = d_idx;
    @(negedge clk);
    bus40.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      for (int j = 0; j < 5; j++)
        e40[8*j +: 8] = 8'(5*i + j);
      check("w40_data",  bus40.out_data,  e40);
      check("w40_valid", bus40.out_valid, 1'b1);
      check("w40_first", bus40.out_first, i == 0);
      check("w40_last",  bus40.out_last,  i == 5);
      @(negedge clk);
    end
    #1;
    check("w40_idle",  bus40.out_valid, 1'b0);
    check("w40_cwcnt", cw40, 32'd1);
    check("w40_ovf",   ovf40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
